// File: rtl/seq_divider.sv
// Sequential signed 32/16 restoring divider: one quotient bit per clock, sign fix-up on the final edge.
// Results are registered and held until the next operation completes.
module seq_divider (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        finished,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [15:0] abs16(input logic [15:0] v);
    abs16 = v[15] ? (16'd0 - v) : v;
  endfunction

  state_e      state_q;
  logic [31:0] dq_q;
  logic [31:0] dq_d;
  logic [15:0] dvs_q;
  logic [16:0] pr_q;
  logic [16:0] pr_d;
  logic [4:0]  cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        dz_q;
  logic [31:0] quotient_q;
  logic [15:0] remainder_q;
  logic        busy_q;
  logic        finished_q;
  logic        div_zero_q;

  logic [16:0] pr_shift_s;
  logic [16:0] pr_diff_s;
  logic        qbit_s;
  logic        unused_s;

  // The top partial-remainder bit is always clear after an iteration, so only [15:0] feeds the shift.
  assign unused_s = pr_q[16];

  // One restoring shift-subtract step; dq holds remaining dividend bits and collects quotient bits.
  always_comb begin
    pr_shift_s = {pr_q[15:0], dq_q[31]};
    pr_diff_s  = pr_shift_s - {1'b0, dvs_q};
    if (pr_shift_s >= {1'b0, dvs_q}) begin
      pr_d   = pr_diff_s;
      qbit_s = 1'b1;
    end else begin
      pr_d   = pr_shift_s;
      qbit_s = 1'b0;
    end
    dq_d = {dq_q[30:0], qbit_s};
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      dq_q        <= 32'd0;
      dvs_q       <= 16'd0;
      pr_q        <= 17'd0;
      cnt_q       <= 5'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 16'd0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dq_q      <= abs32(dividend);
            dvs_q     <= abs16(divisor);
            neg_quo_q <= dividend[31] ^ divisor[15];
            neg_rem_q <= dividend[31];
            dz_q      <= (divisor == 16'd0);
            pr_q      <= 17'd0;
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            state_q   <= DIVIDE;
          end else begin
            state_q <= IDLE;
          end
        end
        DIVIDE: begin
          pr_q  <= pr_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= FIXUP;
          end else begin
            state_q <= DIVIDE;
          end
        end
        FIXUP: begin
          // Divide-by-zero saturates toward the dividend's sign; the iterated result is discarded.
          if (dz_q) begin
            quotient_q  <= neg_rem_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
            remainder_q <= 16'd0;
            div_zero_q  <= 1'b1;
          end else begin
            quotient_q  <= neg_quo_q ? (32'd0 - dq_q) : dq_q;
            remainder_q <= neg_rem_q ? (16'd0 - pr_q[15:0]) : pr_q[15:0];
            div_zero_q  <= 1'b0;
          end
          busy_q     <= 1'b0;
          finished_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops them on each finished pulse.
module tb_seq_divider;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        finished;
  logic        div_zero;

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    int          cap;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   cyc;

  seq_divider dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .finished (finished),
    .div_zero (div_zero)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int cap);
    longint sa;
    longint sd;
    longint qq;
    longint rr;
    exp_t   e;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    qq = sa / sd;
    rr = sa % sd;
    e.q = 32'(qq);
    e.r = 16'(rr);
    e.dz = 1'b0;
    e.cap = cap;
    e.nm = "stream";
    return e;
  endfunction

  // Monitor: every finished pulse must match the oldest outstanding expectation, 33 edges after capture.
  always @(negedge sys_clk) begin
    if (!sys_rst && finished) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_finished actual=1 expected=0 quotient=%0h", quotient);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_quotient"}, quotient, e.q);
        chk({e.nm, "_remainder"}, {16'd0, remainder}, {16'd0, e.r});
        chk({e.nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
        chk({e.nm, "_latency"}, 32'(cyc - e.cap), 32'd33);
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input logic [31:0] eq,
                       input logic [15:0] er, input logic edz, input string nm);
    int   n;
    int   busy_cnt;
    exp_t e;
    @(negedge sys_clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.cap = cyc + 1; e.nm = nm;
    exp_q.push_back(e);
    @(negedge sys_clk);
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (!finished && n < 100) begin
      if (busy) busy_cnt++;
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(negedge sys_clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_finished expected=finished", nm);
    end
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int   i;
    int   ncap;
    int   n;
    int   x;
    exp_t e;
    checks   = 0;
    failures = 0;
    sys_rst  = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 16'd0;
    #12;
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_finished", {31'd0, finished}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    do_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, "p100_p7");
    do_op(-32'sd100, 16'd7, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, "n100_p7");
    do_op(32'd100, -16'sd7, 32'hFFFF_FFF2, 16'd2, 1'b0, "p100_n7");
    do_op(-32'sd100, -16'sd7, 32'd14, 16'hFFFE, 1'b0, "n100_n7");
    do_op(32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'd0, 1'b0, "min_by_m1");
    do_op(32'h7FFF_FFFF, 16'h8000, 32'hFFFF_0001, 16'h7FFF, 1'b0, "max_by_min16");
    do_op(32'h8000_0000, 16'h8000, 32'h0001_0000, 16'd0, 1'b0, "min_by_min16");
    do_op(32'd5, 16'd0, 32'h7FFF_FFFF, 16'd0, 1'b1, "p5_by_0");
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("dz_held", {31'd0, div_zero}, 32'd1);
    chk("dz_q_held", quotient, 32'h7FFF_FFFF);
    do_op(-32'sd5, 16'd0, 32'h8000_0000, 16'd0, 1'b1, "n5_by_0");
    do_op(32'd9, 16'd3, 32'd3, 16'd0, 1'b0, "p9_by_3");

    // Start held high, operands changing every cycle: captures happen only on the edge after finished.
    @(negedge sys_clk);
    start = 1'b1;
    i     = 0;
    ncap  = 0;
    while (ncap < 3 && i < 200) begin
      x = i * 7919 + 12345;
      dividend = (i % 2 == 1) ? 32'(-x) : 32'(x);
      divisor  = (i % 4 >= 2) ? 16'(-((i % 3) + 3)) : 16'((i % 3) + 3);
      if (i == 0 || finished) begin
        exp_q.push_back(model(dividend, divisor, cyc + 1));
        ncap++;
      end
      @(negedge sys_clk);
      i++;
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-operation aborts without a finished pulse.
    @(negedge sys_clk);
    dividend = 32'd1000000;
    divisor  = 16'd3;
    start    = 1'b1;
    e.q = 32'd333333; e.r = 16'd1; e.dz = 1'b0; e.cap = cyc + 1; e.nm = "aborted";
    exp_q.push_back(e);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (9) @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", {16'd0, remainder}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_finished", {31'd0, finished}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    do_op(32'd1000, 16'd10, 32'd100, 16'd0, 1'b0, "p1000_by_10");

    @(negedge sys_clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
